// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: unbuffered LSU results beat FIFO-buffered ALU results,
// with a starvation limit that forces the ALU head through after STARVE_LIMIT lost cycles.
module regfile_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [4:0]              alu_rd,
   input  logic [31:0]             alu_data,
   input  logic                    lsu_valid,
   output logic                    lsu_ready,
   input  logic [4:0]              lsu_rd,
   input  logic [31:0]             lsu_data,
   output logic                    we3,
   output logic [4:0]              a3,
   output logic [31:0]             wd3,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [31:0]             pending_mask
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    r_rd_mem   [DEPTH];
   logic [31:0]   r_data_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve_cnt;

   logic          w_head_v;
   logic          w_force;
   logic          w_lsu_win;
   logic          w_pop;
   logic          w_push;
   logic [4:0]    w_win_rd;
   logic [31:0]   w_win_data;
   logic [31:0]   w_pending;

   assign w_head_v   = (r_count != '0);
   assign w_force    = w_head_v && (r_starve_cnt == SW'(STARVE_LIMIT));
   assign alu_ready  = (r_count < CW'(DEPTH));
   assign lsu_ready  = !w_force;
   assign w_lsu_win  = lsu_valid && !w_force;
   assign w_pop      = !w_lsu_win && w_head_v;
   assign w_push     = alu_valid && alu_ready;
   assign w_win_rd   = w_lsu_win ? lsu_rd   : r_rd_mem[r_rd_ptr];
   assign w_win_data = w_lsu_win ? lsu_data : r_data_mem[r_rd_ptr];

   assign fifo_count   = r_count;
   assign pending_mask = w_pending;

   // Only occupied slots contribute; x0 is never a real hazard
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            w_pending[r_rd_mem[r_rd_ptr + AW'(i)]] = 1'b1;
         end
      end
      w_pending[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd_mem[r_wr_ptr]   <= alu_rd;
         r_data_mem[r_wr_ptr] <= alu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Only losses with a waiting head count toward starvation
         if (w_pop)                      r_starve_cnt <= '0;
         else if (w_lsu_win && w_head_v) r_starve_cnt <= r_starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3 <= 1'b0;
         a3  <= '0;
         wd3 <= '0;
      end else if (w_lsu_win || w_pop) begin
         we3 <= (w_win_rd != 5'd0);
         a3  <= w_win_rd;
         wd3 <= w_win_data;
      end else begin
         we3 <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: hand-computed vector table for the directed scenarios,
// then a queue-based reference model for mid-operation reset and randomized traffic.
module tb_regfile_write_arbiter;
   localparam int DEPTH = 4;
   localparam int LIM   = 3;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [4:0]    alu_rd = '0;
   logic [31:0]   alu_data = '0;
   logic          lsu_valid = 1'b0;
   logic          lsu_ready;
   logic [4:0]    lsu_rd = '0;
   logic [31:0]   lsu_data = '0;
   logic          we3;
   logic [4:0]    a3;
   logic [31:0]   wd3;
   logic [CW-1:0] fifo_count;
   logic [31:0]   pending_mask;

   regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .we3(we3), .a3(a3), .wd3(wd3), .fifo_count(fifo_count), .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat);
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
      alu_valid = av; alu_rd = ard; alu_data = adat;
   endtask

   // Directed vectors: inputs for one cycle, ready flags before the edge, outputs after it
   typedef struct {
      logic lv; logic [4:0] lrd; logic [31:0] ldat;
      logic av; logic [4:0] ard; logic [31:0] adat;
      logic elr; logic ear; logic ewe; logic [4:0] ea3; logic [31:0] ewd;
      int ecnt; logic [31:0] emask;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic elr, input logic ear, input logic ewe, input logic [4:0] ea3,
                      input logic [31:0] ewd, input int ecnt, input logic [31:0] emask);
      vec_t v;
      v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.av = av; v.ard = ard; v.adat = adat;
      v.elr = elr; v.ear = ear; v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd;
      v.ecnt = ecnt; v.emask = emask;
      tv.push_back(v);
   endtask

   // Reference model: FIFO as a queue, starvation as a plain counter of lost cycles
   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
   ent_t        q[$];
   int          starve;
   logic        m_we;
   logic [4:0]  m_a3;
   logic [31:0] m_wd;

   function automatic logic [31:0] m_mask();
      logic [31:0] m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic model_reset();
      q.delete(); starve = 0; m_we = 1'b0; m_a3 = '0; m_wd = '0;
   endtask

   task automatic step_model(input string tag);
      bit   head_v, frc, lwin, acc;
      ent_t e;
      #1;
      head_v = (q.size() != 0);
      frc    = head_v && (starve == LIM);
      acc    = alu_valid && (q.size() < DEPTH);
      chk({tag, "_lsu_ready"}, 32'(lsu_ready), 32'(!frc));
      chk({tag, "_alu_ready"}, 32'(alu_ready), 32'(q.size() < DEPTH));
      lwin = lsu_valid && !frc;
      if (lwin) begin
         m_we = (lsu_rd != 5'd0); m_a3 = lsu_rd; m_wd = lsu_data;
         if (head_v) starve++;
      end else if (head_v) begin
         e = q.pop_front();
         m_we = (e.rd != 5'd0); m_a3 = e.rd; m_wd = e.data;
         starve = 0;
      end else begin
         m_we = 1'b0;
      end
      if (acc) begin
         e.rd = alu_rd; e.data = alu_data;
         q.push_back(e);
      end
      @(posedge clk); #1;
      chk({tag, "_we3"}, 32'(we3), 32'(m_we));
      chk({tag, "_a3"}, 32'(a3), 32'(m_a3));
      chk({tag, "_wd3"}, wd3, m_wd);
      chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
      chk({tag, "_mask"}, pending_mask, m_mask());
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      // LSU single write, idle
      add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 0, 32'h0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 0, 32'h0);
      // ALU fill against a busy LSU; force pop on the 4th lost cycle
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd1, 32'h10, 1'b1, 1'b1, 1'b1, 5'd9, 32'h900, 1, 32'h2);
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd2, 32'h11, 1'b1, 1'b1, 1'b1, 5'd9, 32'h900, 2, 32'h6);
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd3, 32'h12, 1'b1, 1'b1, 1'b1, 5'd9, 32'h900, 3, 32'hE);
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd4, 32'h13, 1'b1, 1'b1, 1'b1, 5'd9, 32'h900, 4, 32'h1E);
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd5, 32'h14, 1'b0, 1'b0, 1'b1, 5'd1, 32'h10, 3, 32'h1C);
      add(1'b1, 5'd9, 32'h900, 1'b1, 5'd5, 32'h14, 1'b1, 1'b1, 1'b1, 5'd9, 32'h900, 4, 32'h3C);
      // Drain in push order
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h11, 3, 32'h38);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h12, 2, 32'h30);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h13, 1, 32'h20);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h14, 0, 32'h0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h14, 0, 32'h0);
      // Starvation of a single entry rd=7
      add(1'b1, 5'd9, 32'h901, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1, 5'd9, 32'h901, 1, 32'h80);
      add(1'b1, 5'd9, 32'h901, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h901, 1, 32'h80);
      add(1'b1, 5'd9, 32'h901, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h901, 1, 32'h80);
      add(1'b1, 5'd9, 32'h901, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h901, 1, 32'h80);
      add(1'b1, 5'd9, 32'h901, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 0, 32'h0);
      add(1'b1, 5'd9, 32'h901, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h901, 0, 32'h0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h901, 0, 32'h0);
      // x0 writes are consumed without we3
      add(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 1, 32'h0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF, 0, 32'h0);
      add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF, 0, 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("rst_we3", 32'(we3), 32'd0);
      chk("rst_a3", 32'(a3), 32'd0);
      chk("rst_wd3", wd3, 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_mask", pending_mask, 32'd0);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].lv, tv[i].lrd, tv[i].ldat, tv[i].av, tv[i].ard, tv[i].adat);
         #1;
         chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(tv[i].elr));
         chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tv[i].ear));
         @(posedge clk); #1;
         chk($sformatf("v%0d_we3", i), 32'(we3), 32'(tv[i].ewe));
         chk($sformatf("v%0d_a3", i), 32'(a3), 32'(tv[i].ea3));
         chk($sformatf("v%0d_wd3", i), wd3, tv[i].ewd);
         chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tv[i].ecnt));
         chk($sformatf("v%0d_mask", i), pending_mask, tv[i].emask);
      end

      // Mid-operation reset with three entries queued behind a busy LSU
      pulse_reset();
      drive(1'b1, 5'd9, 32'h555, 1'b1, 5'd11, 32'hA1); step_model("mr0");
      drive(1'b1, 5'd9, 32'h555, 1'b1, 5'd12, 32'hA2); step_model("mr1");
      drive(1'b1, 5'd9, 32'h555, 1'b1, 5'd13, 32'hA3); step_model("mr2");
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_we3", 32'(we3), 32'd0);
      chk("mr_a3", 32'(a3), 32'd0);
      chk("mr_wd3", wd3, 32'd0);
      chk("mr_count", 32'(fifo_count), 32'd0);
      chk("mr_mask", pending_mask, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step_model($sformatf("mr_idle%0d", i));

      // Randomized traffic: heavy load first to exercise full/force, then light load
      for (int i = 0; i < 600; i++) begin
         int pa, pl;
         pa = (i < 300) ? 75 : 30;
         pl = (i < 300) ? 70 : 25;
         drive(logic'($urandom_range(0, 99) < pl), 5'($urandom_range(0, 31)), $urandom,
               logic'($urandom_range(0, 99) < pa), 5'($urandom_range(0, 31)), $urandom);
         step_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Drives the single write port (A3/WD3/WE3) of the integer register file from two result producers: the ALU/execute path and the load/store unit (LSU).
- ALU results are buffered in a small FIFO. LSU results are unbuffered and have priority, subject to an anti-starvation limit.
- A combinational pending-register mask is exported to the hazard unit, so decode can stall on registers whose writes are still in flight.

Parameters:
- DEPTH, 4, ALU result FIFO depth; power of two, minimum 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty ALU FIFO may lose arbitration before it is forced to win; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  FIFO can accept; equals (count < DEPTH).
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- lsu_valid  input  1  load result valid.
- lsu_ready  output  1  LSU result accepted this cycle.
- lsu_rd  input  5  load destination register.
- lsu_data  input  32  load data.
- we3  output  1  register file write enable (registered).
- a3  output  5  register file write address (registered).
- wd3  output  32  register file write data (registered).
- fifo_count  output  $clog2(DEPTH)+1  ALU FIFO occupancy.
- pending_mask  output  32  bit r set if any FIFO entry targets r, r != 0.

Behaviour:
- Reset (async assert, sync release):
  - we3=0, a3=0, wd3=0.
  - FIFO empty: fifo_count=0, pointers=0.
  - starve_cnt=0, pending_mask=0.
  - Reset mid-operation discards all FIFO contents and any write not yet presented. No partial write is issued after reset.
- ALU push:
  - Occurs on an edge where alu_valid && alu_ready.
  - alu_ready is low when full. There is no pass-through on full, even if a pop occurs in the same cycle.
- Arbitration, evaluated combinationally each cycle. Let head_v = (fifo_count != 0).
  - force = head_v && (starve_cnt == STARVE_LIMIT).
  - lsu_ready = !force.
  - LSU wins if lsu_valid && !force.
  - Otherwise ALU head wins if head_v; a pop occurs.
  - Otherwise there is no winner.
- starve_cnt update:
  - Increments on each edge where LSU wins and head_v=1.
  - Clears on any pop.
  - Holds otherwise, including when the FIFO is empty, in which case it is 0.
- Output register, updated every edge:
  - With a winner: a3/wd3 take the winner's rd/data. we3 = (winner rd != 0).
  - Writes to x0 are consumed (handshake/pop happens) but we3 stays 0.
  - Without a winner: we3=0; a3/wd3 hold their previous values.
- Latency:
  - LSU accepted at edge E: we3 high in the cycle after E.
  - ALU pushed at edge E into an empty FIFO, with no LSU contention: popped at E+1; we3 high after E+1. Minimum latency is 2 cycles.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering:
  - ALU results are written in push order.
  - No ordering is guaranteed between the LSU and ALU paths; the hazard unit uses pending_mask to enforce correctness.
- pending_mask:
  - OR of onehot(rd) over valid FIFO entries, with bit 0 forced to 0.
  - Does not include the output register stage.
  - Updates the cycle after a push or pop edge.
- The block never back-pressures LSU except on a force cycle.
- Maximum LSU stall is 1 cycle per STARVE_LIMIT+1 cycles.

Test Plan:
- Reset, idle: hold rst_n=0 for 3 cycles, then release -> we3=0, a3=0, wd3=0, fifo_count=0, pending_mask=0, alu_ready=1, lsu_ready=1.
- LSU single write: lsu_valid=1, lsu_rd=5, lsu_data=0xDEADBEEF for 1 cycle -> the next cycle has we3=1, a3=5, wd3=0xDEADBEEF; the cycle after has we3=0.
- ALU fill, back-pressure and drain, with lsu_valid held high:
  - Push 5 results: rd=1..5, data=0x10..0x14.
  - FIFO holds 4; alu_ready drops after the 4th push; pending_mask=0x1E; rd=5 waits.
  - Then drop lsu_valid -> writes rd 1..4 in order, then 5; fifo_count returns to 0.
- Starvation, with STARVE_LIMIT=3: FIFO holds 1 entry (rd=7) and lsu_valid is held high -> 3 LSU writes, then 1 cycle with lsu_ready=0 and we3=1, a3=7; the LSU resumes next cycle.
- x0 suppression: push ALU rd=0 data=0xFFFF and LSU rd=0 -> both are consumed (fifo_count returns to 0, lsu_ready=1); we3 is never asserted; pending_mask bit 0 stays 0.
- Reset mid-operation: FIFO holds 3 entries; assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately; after release, no write from the old entries ever appears on we3.
